// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Initiator side of the word-addressed instruction/data memory interface.
// Takes one load/store at a time from the datapath, drives the word-only memory
// and returns an aligned, zero/sign-extended result. Byte and halfword stores
// are performed as a read-modify-write of the containing word.
//
// Ports
//   clk            : system clock, rising edge
//   reset          : asynchronous, active-low reset
//   req_valid      : request present
//   req_ready      : request accepted when high (IDLE only)
//   req_write      : 1 = store, 0 = load
//   req_size       : 0 byte, 1 halfword, 2 word, 3 illegal
//   req_signed     : sign-extend subword loads
//   req_addr       : byte address
//   req_wdata      : store data, right-aligned
//   resp_valid     : one-cycle response pulse
//   resp_rdata     : load result (0 for stores and errors)
//   resp_err       : misaligned / illegal size / out of range
//   mem_address    : word-aligned memory address
//   mem_write_data : memory write data
//   mem_read       : MemRead
//   mem_write      : MemWrite
//   mem_rdata      : memory read data (combinational)
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int unsigned MEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_RESP = 2'd3
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_ILL  = 2'd3;

   state_t      r_state;
   state_t      w_next;

   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [1:0]  r_size;
   logic        r_signed;
   logic        r_write;
   logic        r_err;
   logic [31:0] r_data_q;

   logic        w_accept;
   logic        w_err;
   logic [31:0] w_aligned;
   logic [31:0] w_merge;
   logic [31:0] w_load;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_accept  = (r_state == S_IDLE) && req_valid;
   assign w_aligned = {r_addr[31:2], 2'b00};

   // Request legality, evaluated on the live request at the accept edge.
   always_comb begin
      w_err = 1'b0;
      if (req_size == SZ_ILL)
         w_err = 1'b1;
      if ((req_size == SZ_HALF) && req_addr[0])
         w_err = 1'b1;
      if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
         w_err = 1'b1;
      if (req_addr >= MEM_BYTES)
         w_err = 1'b1;
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Request latch and read-data capture
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr   <= '0;
         r_wdata  <= '0;
         r_size   <= '0;
         r_signed <= 1'b0;
         r_write  <= 1'b0;
         r_err    <= 1'b0;
         r_data_q <= '0;
      end else begin
         if (w_accept) begin
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_write  <= req_write;
            r_err    <= w_err;
         end
         if (r_state == S_RD)
            r_data_q <= mem_rdata;
      end
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (w_err)
                  w_next = S_RESP;
               else if (!req_write)
                  w_next = S_RD;
               else if (req_size == SZ_WORD)
                  w_next = S_WR;
               else
                  w_next = S_RD;   // read phase of read-modify-write
            end
         end
         S_RD:    w_next = r_write ? S_WR : S_RESP;
         S_WR:    w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Subword store merge into the word captured during RD
   always_comb begin
      w_merge = r_data_q;
      case (r_size)
         SZ_BYTE: begin
            case (r_addr[1:0])
               2'd0:    w_merge[7:0]   = r_wdata[7:0];
               2'd1:    w_merge[15:8]  = r_wdata[7:0];
               2'd2:    w_merge[23:16] = r_wdata[7:0];
               default: w_merge[31:24] = r_wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            if (r_addr[1])
               w_merge[31:16] = r_wdata[15:0];
            else
               w_merge[15:0]  = r_wdata[15:0];
         end
         default: w_merge = r_wdata;
      endcase
   end

   // Load lane extraction and extension
   always_comb begin
      w_byte = r_data_q[7:0];
      case (r_addr[1:0])
         2'd0:    w_byte = r_data_q[7:0];
         2'd1:    w_byte = r_data_q[15:8];
         2'd2:    w_byte = r_data_q[23:16];
         default: w_byte = r_data_q[31:24];
      endcase
      w_half = r_addr[1] ? r_data_q[31:16] : r_data_q[15:0];

      w_load = r_data_q;
      case (r_size)
         SZ_BYTE: w_load = {{24{r_signed & w_byte[7]}}, w_byte};
         SZ_HALF: w_load = {{16{r_signed & w_half[15]}}, w_half};
         default: w_load = r_data_q;
      endcase
   end

   // Moore output decode; async reset forces IDLE so mem_write drops at once.
   always_comb begin
      req_ready      = 1'b0;
      resp_valid     = 1'b0;
      resp_rdata     = '0;
      resp_err       = 1'b0;
      mem_address    = '0;
      mem_write_data = '0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      case (r_state)
         S_IDLE: req_ready = 1'b1;
         S_RD: begin
            mem_read    = 1'b1;
            mem_address = w_aligned;
         end
         S_WR: begin
            mem_write      = 1'b1;
            mem_address    = w_aligned;
            mem_write_data = w_merge;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            resp_err   = r_err;
            if (!r_err && !r_write)
               resp_rdata = w_load;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_rdata;

   mem_access_unit #(.MEM_BYTES(1024)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_size       (req_size),
      .req_signed     (req_signed),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_err       (resp_err),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_rdata      (mem_rdata)
   );

   always #5 clk = ~clk;

   // Word memory model: combinational read, write on rising edge
   logic [31:0] tb_mem [0:255];
   assign mem_rdata = tb_mem[mem_address[9:2]];
   always @(posedge clk)
      if (mem_write)
         tb_mem[mem_address[9:2]] <= mem_write_data;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          nrd;
      int          nwr;
      logic [31:0] wdata;
      logic [31:0] addr;
   } exp_t;

   exp_t sb[$];
   bit   hold_chk = 1'b0;

   // Monitor: samples on the falling edge
   int          cyc = 0;
   int          acc_cyc = 0;
   int          last_resp = 0;
   int          cur_rd = 0;
   int          cur_wr = 0;
   logic [31:0] cur_wd = '0;
   exp_t        m_e;

   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            cur_rd = 0;
            cur_wr = 0;
         end else begin
            cyc++;
            check("ready_moore", 64'(req_ready), 64'(!(mem_read || mem_write || resp_valid)));
            if (resp_valid) begin
               if (sb.size() == 0) begin
                  check("unexpected_resp", 64'd1, 64'd0);
               end else begin
                  m_e = sb.pop_front();
                  check("rdata", 64'(resp_rdata), 64'(m_e.rdata));
                  check("err", 64'(resp_err), 64'(m_e.err));
                  check("latency", 64'(cyc - acc_cyc), 64'(m_e.lat));
                  check("rd_cycles", 64'(cur_rd), 64'(m_e.nrd));
                  check("wr_cycles", 64'(cur_wr), 64'(m_e.nwr));
                  if (m_e.nwr > 0)
                     check("wr_data", 64'(cur_wd), 64'(m_e.wdata));
               end
               last_resp = cyc;
            end else begin
               check("quiet_resp", {31'd0, resp_err, resp_rdata}, 64'd0);
            end
            if (mem_read || mem_write) begin
               if (sb.size() > 0)
                  check("mem_addr", 64'(mem_address), 64'({sb[0].addr[31:2], 2'b00}));
               if (mem_read)
                  cur_rd++;
               if (mem_write) begin
                  cur_wr++;
                  cur_wd = mem_write_data;
               end
            end else begin
               check("quiet_mem", {mem_address, mem_write_data}, 64'd0);
            end
            if (req_valid && req_ready) begin
               acc_cyc = cyc;
               cur_rd  = 0;
               cur_wr  = 0;
               cur_wd  = '0;
               if (hold_chk) begin
                  check("hold_gap", 64'(cyc - last_resp), 64'd1);
                  hold_chk = 1'b0;
               end
            end
         end
      end
   end

   task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
      req_write  = w;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      req_valid  = 1'b1;
   endtask

   task automatic push(input logic [31:0] erd, input logic eerr, input int lat,
                       input int nrd, input int nwr, input logic [31:0] ewd,
                       input logic [31:0] a);
      exp_t e;
      e.rdata = erd;
      e.err   = eerr;
      e.lat   = lat;
      e.nrd   = nrd;
      e.nwr   = nwr;
      e.wdata = ewd;
      e.addr  = a;
      sb.push_back(e);
   endtask

   task automatic wait_ready();
      int t;
      t = 0;
      while (!req_ready && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      if (!req_ready)
         check("ready_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      if (sb.size() != 0) begin
         check("resp_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   // Issue one request and wait for its response. Called at posedge+#1.
   task automatic send(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eerr, input int lat,
                       input int nrd, input int nwr, input logic [31:0] ewd);
      wait_ready();
      drive(w, sz, sg, a, wd);
      push(erd, eerr, lat, nrd, nwr, ewd, a);
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_drain();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 256; i++)
         tb_mem[i] = '0;
      tb_mem[32] = 32'h89ABCDEF;   // byte address 0x80
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_size   = 2'd0;
      req_signed = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      reset      = 1'b0;

      #13;
      check("rst_ready", 64'(req_ready), 64'd1);
      check("rst_resp", {30'd0, resp_valid, resp_err, resp_rdata}, 64'd0);
      check("rst_mem", {mem_address, mem_write_data}, 64'd0);
      check("rst_rdwr", {62'd0, mem_read, mem_write}, 64'd0);
      @(negedge clk); #2;
      reset = 1'b1;
      @(posedge clk); #1;

      // Word and subword loads
      send(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'h89ABCDEF, 1'b0, 2, 1, 0, 32'h0);
      send(1'b0, 2'd0, 1'b1, 32'h83, 32'h0, 32'hFFFFFF89, 1'b0, 2, 1, 0, 32'h0);
      send(1'b0, 2'd0, 1'b0, 32'h82, 32'h0, 32'h000000AB, 1'b0, 2, 1, 0, 32'h0);
      send(1'b0, 2'd1, 1'b1, 32'h82, 32'h0, 32'hFFFF89AB, 1'b0, 2, 1, 0, 32'h0);
      send(1'b0, 2'd1, 1'b0, 32'h80, 32'h0, 32'h0000CDEF, 1'b0, 2, 1, 0, 32'h0);

      // Byte store (RMW) then read back
      send(1'b1, 2'd0, 1'b0, 32'h81, 32'h00000055, 32'h0, 1'b0, 3, 1, 1, 32'h89AB55EF);
      send(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'h89AB55EF, 1'b0, 2, 1, 0, 32'h0);
      send(1'b0, 2'd0, 1'b1, 32'h81, 32'h0, 32'h00000055, 1'b0, 2, 1, 0, 32'h0);

      // Word store then read back
      send(1'b1, 2'd2, 1'b0, 32'h84, 32'h12345678, 32'h0, 1'b0, 2, 0, 1, 32'h12345678);
      send(1'b0, 2'd2, 1'b0, 32'h84, 32'h0, 32'h12345678, 1'b0, 2, 1, 0, 32'h0);

      // Error requests: no memory access, latency 1
      send(1'b0, 2'd2, 1'b0, 32'h82,  32'h0,      32'h0, 1'b1, 1, 0, 0, 32'h0);
      send(1'b1, 2'd1, 1'b0, 32'h81,  32'hFFFF,   32'h0, 1'b1, 1, 0, 0, 32'h0);
      send(1'b0, 2'd2, 1'b0, 32'h400, 32'h0,      32'h0, 1'b1, 1, 0, 0, 32'h0);
      send(1'b1, 2'd3, 1'b0, 32'h80,  32'hDEAD,   32'h0, 1'b1, 1, 0, 0, 32'h0);
      send(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'h89AB55EF, 1'b0, 2, 1, 0, 32'h0);

      // Halfword store to upper half, subword loads, last valid word
      send(1'b1, 2'd1, 1'b0, 32'h82, 32'h0000BEEF, 32'h0, 1'b0, 3, 1, 1, 32'hBEEF55EF);
      send(1'b0, 2'd1, 1'b1, 32'h82, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 1, 0, 32'h0);
      send(1'b0, 2'd0, 1'b1, 32'h80, 32'h0, 32'hFFFFFFEF, 1'b0, 2, 1, 0, 32'h0);
      send(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, 32'h00000000, 1'b0, 2, 1, 0, 32'h0);

      // Reset during the WR cycle of SH 0x80
      wait_ready();
      drive(1'b1, 2'd1, 1'b0, 32'h80, 32'h00001111);
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int t = 0; t < 10 && !mem_write; t++)
         @(negedge clk);
      check("rmw_reached_wr", 64'(mem_write), 64'd1);
      #2;
      reset = 1'b0;
      sb.delete();
      #1;
      check("rst_wr_drop", 64'(mem_write), 64'd0);
      check("rst_mid_ready", 64'(req_ready), 64'd1);
      check("rst_mid_resp", 64'(resp_valid), 64'd0);
      @(posedge clk);
      @(negedge clk); #2;
      reset = 1'b1;
      @(posedge clk); #1;
      check("post_rst_ready", 64'(req_ready), 64'd1);
      check("post_rst_resp", 64'(resp_valid), 64'd0);
      check("rst_mem_kept", 64'(tb_mem[32]), 64'h00000000BEEF55EF);
      send(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'hBEEF55EF, 1'b0, 2, 1, 0, 32'h0);

      // req_valid held through RESP: second request accepted in next IDLE only
      wait_ready();
      drive(1'b0, 2'd2, 1'b0, 32'h84, 32'h0);
      push(32'h12345678, 1'b0, 2, 1, 0, 32'h0, 32'h84);
      @(posedge clk); #1;
      drive(1'b0, 2'd1, 1'b0, 32'h84, 32'h0);
      push(32'h00005678, 1'b0, 2, 1, 0, 32'h0, 32'h84);
      hold_chk = 1'b1;
      for (int t = 0; t < 20 && (sb.size() != 1 || !req_ready); t++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_drain();
      check("hold_seen", 64'(hold_chk), 64'd0);

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the word-addressed instruction/data memory interface.
- Accepts one load/store request at a time from the CPU datapath through a valid/ready handshake.
- Drives Address/Write_data/MemRead/MemWrite toward the memory and returns an aligned, extended result.
- The memory is word-only, so byte/halfword stores are done as read-modify-write.

Parameters:
MEM_BYTES, 1024, addressable byte range; a request with addr >= MEM_BYTES is an error.

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_write  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal
req_signed  input  1  sign-extend subword loads
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (low lane)
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  load result; 0 for stores and errors
resp_err  output  1  misaligned, illegal size or out-of-range; valid with resp_valid
mem_address  output  32  word-aligned address to memory
mem_write_data  output  32  write data to memory
mem_read  output  1  MemRead
mem_write  output  1  MemWrite
mem_rdata  input  32  Mem_data from memory (combinational read)

Behaviour:
- Reset (reset low, asynchronous): state = IDLE, all latched registers = 0.
  - Outputs during reset: resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_read = 0, mem_write = 0, mem_address = 0, mem_write_data = 0, req_ready = 1.
  - Reset mid-operation aborts the operation. mem_write drops immediately, so no write occurs at the next edge.
- States: IDLE, RD, WR, RESP. mem_read, mem_write and req_ready are Moore decodes of state.
- IDLE: req_ready = 1. On req_valid, latch addr, wdata, size, signed and write.
  - Error if any of: size == 3; size == 1 with addr[0] = 1; size == 2 with addr[1:0] != 0; addr >= MEM_BYTES.
  - Error -> RESP with err flag set; no memory access is made.
  - Otherwise: load -> RD; word store -> WR; subword store -> RD (read phase of RMW).
- RD: mem_read = 1, mem_address = {addr[31:2], 2'b00}. mem_rdata is captured into data_q at the closing edge.
  - Load -> RESP; subword store -> WR.
- WR: mem_write = 1, same aligned mem_address.
  - Word store: mem_write_data = wdata.
  - Byte store: data_q with lane addr[1:0] replaced by wdata[7:0].
  - Halfword store: data_q with half addr[1] replaced by wdata[15:0].
  - Next state: RESP.
- RESP: resp_valid = 1 for exactly one cycle, req_ready = 0 (req_valid is ignored), then -> IDLE.
  - A new request is accepted in the following IDLE cycle at the earliest.
- Lanes are little-endian: byte n occupies bits [8n+7:8n]; halfword h occupies bits [16h+15:16h].
- Load extraction: the selected lane is zero-extended, or sign-extended when req_signed = 1. req_signed is ignored for word loads.
- resp_rdata and resp_err hold their values only while resp_valid is high; otherwise they are 0.
- mem_address and mem_write_data are 0 in IDLE and RESP.
- Latency, counted from the accept edge to the edge at which resp_valid is sampled high:
  - error: 1
  - load: 2
  - word store: 2
  - subword store: 3
- Throughput: one request per (latency + 1) cycles.

Test Plan:
- Word load: preload word 0x80 = 0x89ABCDEF; LW 0x80 -> mem_read high for one cycle with mem_address = 0x80; resp_valid 2 cycles after accept; resp_rdata = 0x89ABCDEF; resp_err = 0.
- Subword loads from 0x80:
  - LB signed 0x83 -> 0xFFFFFF89
  - LBU 0x82 -> 0x000000AB
  - LH signed 0x82 -> 0xFFFF89AB
  - LHU 0x80 -> 0x0000CDEF
- Byte store: SB 0x81, wdata 0x00000055 -> one RD cycle, then a WR cycle with mem_write_data = 0x89AB55EF; resp 3 cycles after accept; a following LW 0x80 returns 0x89AB55EF.
- Word store: SW 0x84, wdata 0x12345678 -> mem_read never asserted; one WR cycle with mem_address = 0x84; a following LW 0x84 returns 0x12345678.
- Error requests: LW 0x82, SH 0x81, LW 0x400 (MEM_BYTES = 1024), size = 3 -> each gives resp_valid and resp_err = 1 one cycle after accept, resp_rdata = 0; mem_read and mem_write stay 0; memory unchanged.
- Reset and handshake:
  - Pull reset low during the WR cycle of SH 0x80 -> mem_write falls asynchronously; word 0x80 is unchanged; after release, req_ready = 1 and resp_valid = 0.
  - Holding req_valid high through RESP -> the request is accepted only in the next IDLE cycle.
